hamming_encoder_tx: RTL and testbench
=====================================

Name: hamming_encoder_tx

Overview:
Sequential Hamming(7,4)-per-nibble encoder that produces the codewords the counter/syndrome path checks. It accepts a WIDTH-bit data word on a valid/ready input and computes 3 parity bits per 4-bit block, one block per clock. It then presents the data and parity pair on a valid/ready output. The block sits upstream of the protected-storage/corrector path, and verification uses it to generate known-good codewords.

Parameters:
WIDTH, 16, data width; must be a multiple of 4
BLOCKS, WIDTH/4, number of 4-bit blocks
PARITY_BITS, BLOCKS*3, total parity width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word (high only in IDLE)
in_data  input  WIDTH  data word
out_valid  output  1  codeword valid
out_ready  input  1  consumer accepts codeword
out_data  output  WIDTH  latched data word
out_parity  output  PARITY_BITS  parity; block i occupies bits [i*3+2:i*3]
busy  output  1  high in ENCODE or OUT
words_sent  output  16  count of completed output handshakes, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n low, async): state=IDLE, out_valid=0, out_data=0, out_parity=0, busy=0, words_sent=0, block index=0. Reset mid-ENCODE or mid-OUT abandons the word; nothing is emitted after release.
- Parity for block i, with d = data[i*4+3:i*4]:
  - p[i*3+2] = d0^d2^d3
  - p[i*3+1] = d0^d1^d3
  - p[i*3+0] = d0^d1^d2
- States:
  - IDLE: in_ready=1 (combinational from state). On in_valid&in_ready: latch in_data into out_data, clear the parity register, set idx=0, go to ENCODE.
  - ENCODE: each edge writes the parity bits for block idx and increments idx. At the edge with idx==BLOCKS-1, go to OUT. in_ready=0; in_valid is ignored.
  - OUT: out_valid=1. out_data and out_parity stay stable until the handshake. On out_valid&out_ready: words_sent+=1, go to IDLE, out_valid drops the next cycle.
- Latency:
  - out_valid is first high BLOCKS edges after the accepting edge (4 for the defaults).
  - Best-case throughput is one word per BLOCKS+2 cycles: the next accept happens in the cycle after the output handshake, with no same-cycle accept.
- out_ready held high before OUT has no effect. The handshake completes in the first OUT cycle.
- out_data/out_parity keep their last values in IDLE; they are valid only while out_valid=1.
- in_data changes after acceptance have no effect on the word in flight.
- words_sent wraps modulo 2^16 with no saturation.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, ENCODE, OUT}
  - BLOCK_W=4 and PAR_PER_BLOCK=3 constants
  - function nibble_parity(logic [3:0]) returning logic [2:0] with the equations above, reused by the syndrome side.
- One sub-module is natural: hamming_block_enc (purely combinational 4->3 encoder), instantiated once and muxed by idx.

Test Plan:
- Reset then in_data=0x1234 with in_valid=1, out_ready=1 -> in_ready drops after accept; out_valid rises 4 edges later with out_data=0x1234, out_parity=0xEE5; words_sent=1 after handshake.
- in_data=0xFFFF -> out_parity=0xFFF. in_data=0x0000 -> out_parity=0x000. in_data=0x0002 -> out_parity=0x003.
- Back-pressure: out_ready=0 for 10 cycles while in OUT, in_valid held with 0xAAAA -> out_valid stays high, outputs stable, no second accept. Release out_ready -> one handshake, then 0xAAAA accepted the next cycle.
- in_data changed to 0x5555 during ENCODE for the word 0x0001 -> output data=0x0001, parity=0x007.
- rst_n pulsed low mid-ENCODE -> out_valid=0 and words_sent=0 immediately. After release, in_ready=1 and no stale output appears.
- Force words_sent to 0xFFFF via 65535 transfers (or a fast-path bench) then one more handshake -> words_sent=0x0000.

Source files
------------

// File: rtl/hamming_encoder_tx_pkg.sv
// rtl/hamming_encoder_tx_pkg.sv - shared types, constants and nibble parity function
package hamming_encoder_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    OUT    = 2'd2
  } state_e;

  localparam int BLOCK_W       = 4;
  localparam int PAR_PER_BLOCK = 3;

  // Hamming(7,4) parity for one nibble; the syndrome side reuses this exact ordering
  function automatic logic [PAR_PER_BLOCK-1:0] nibble_parity(input logic [BLOCK_W-1:0] d);
    logic [PAR_PER_BLOCK-1:0] p;
    p[2] = d[0] ^ d[2] ^ d[3];
    p[1] = d[0] ^ d[1] ^ d[3];
    p[0] = d[0] ^ d[1] ^ d[2];
    return p;
  endfunction

endpackage

// File: rtl/hamming_encoder_tx_if.sv
// rtl/hamming_encoder_tx_if.sv - input word and output codeword handshake bundle
interface hamming_encoder_tx_if #(
  parameter int WIDTH = 16
);
  localparam int PARITY_BITS = (WIDTH / 4) * 3;

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [PARITY_BITS-1:0] out_parity;

  // producer of words and consumer of codewords
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_parity
  );

  // the encoder itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_parity
  );
endinterface

// File: rtl/hamming_encoder_tx_block_enc.sv
// rtl/hamming_encoder_tx_block_enc.sv - combinational 4-bit to 3-bit parity encoder
module hamming_block_enc
  import hamming_encoder_tx_pkg::*;
(
  input  logic [BLOCK_W-1:0]       d,
  output logic [PAR_PER_BLOCK-1:0] p
);

  assign p = nibble_parity(d);

endmodule

// File: rtl/hamming_encoder_tx.sv
// rtl/hamming_encoder_tx.sv - sequential per-nibble Hamming(7,4) parity generator
module hamming_encoder_tx
  import hamming_encoder_tx_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hamming_encoder_tx_if.slave     bus,
  output logic                    busy,
  output logic [15:0]             words_sent
);

  localparam int BLOCKS      = WIDTH / BLOCK_W;
  localparam int PARITY_BITS = BLOCKS * PAR_PER_BLOCK;
  localparam int IDX_W       = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [PARITY_BITS-1:0] parity_q, parity_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic [15:0]            words_sent_q, words_sent_d;

  logic [BLOCK_W-1:0]       nib;
  logic [PAR_PER_BLOCK-1:0] nib_par;

  // one shared encoder, fed the nibble selected by the block index
  assign nib = data_q[idx_q*BLOCK_W +: BLOCK_W];

  hamming_block_enc u_enc (
    .d (nib),
    .p (nib_par)
  );

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = data_q;
  assign bus.out_parity = parity_q;
  assign busy           = busy_q;
  assign words_sent     = words_sent_q;

  // next-state: accept in IDLE, one nibble per cycle in ENCODE, hold until taken in OUT
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    parity_d     = parity_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    words_sent_d = words_sent_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d   = bus.in_data;
          parity_d = '0;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = ENCODE;
        end
      end
      ENCODE: begin
        parity_d[idx_q*PAR_PER_BLOCK +: PAR_PER_BLOCK] = nib_par;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          words_sent_d = words_sent_q + 16'd1;
          out_valid_d  = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // state register; async reset abandons any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      parity_q     <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      parity_q     <= parity_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      words_sent_q <= words_sent_d;
    end
  end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// tb/tb_hamming_encoder_tx.sv - self-checking bench for hamming_encoder_tx
module tb_hamming_encoder_tx;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] words_sent;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] ws_exp = 16'd0;

  hamming_encoder_tx_if #(.WIDTH(16)) bus ();

  hamming_encoder_tx #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .words_sent (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [15:0] late;
    logic [11:0] par;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one word, check acceptance, latency and the resulting codeword
  task automatic run_word(input logic [15:0] d, input logic [15:0] late, input logic [11:0] p);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("wait_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = late;
    check("in_ready_after_accept", {31'd0, bus.in_ready}, 32'd0);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", n, 32'd4);
    check("out_data", {16'd0, bus.out_data}, {16'd0, d});
    check("out_parity", {20'd0, bus.out_parity}, {20'd0, p});
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h1234, 12'hEE5};
    vecs[1] = '{16'hFFFF, 16'h0000, 12'hFFF};
    vecs[2] = '{16'h0000, 16'hFFFF, 12'h000};
    vecs[3] = '{16'h0002, 16'hFFFD, 12'h003};
    vecs[4] = '{16'hAAAA, 16'h5555, 12'hB6D};
    vecs[5] = '{16'h5555, 16'hAAAA, 12'h492};
    vecs[6] = '{16'h0001, 16'h5555, 12'h007};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    check("rst_out_parity", {20'd0, bus.out_parity}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_words", {16'd0, words_sent}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // table: each word is taken on the first OUT cycle since out_ready is high
    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i].data, vecs[i].late, vecs[i].par);
      tick();
      ws_exp = ws_exp + 16'd1;
      check("handshake_valid_drop", {31'd0, bus.out_valid}, 32'd0);
      check("handshake_words", {16'd0, words_sent}, {16'd0, ws_exp});
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_hold_data", {16'd0, bus.out_data}, {16'd0, vecs[i].data});
    end

    // back-pressure: word held in OUT, pending 0xAAAA must not be taken early
    bus.out_ready = 1'b0;
    run_word(16'h0002, 16'h0002, 12'h003);
    bus.in_data  = 16'hAAAA;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_data", {16'd0, bus.out_data}, 32'h0002);
      check("bp_parity", {20'd0, bus.out_parity}, 32'h003);
    end
    check("bp_words", {16'd0, words_sent}, {16'd0, ws_exp});
    bus.out_ready = 1'b1;
    tick();
    ws_exp = ws_exp + 16'd1;
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("bp_release_words", {16'd0, words_sent}, {16'd0, ws_exp});
    tick();
    bus.in_valid = 1'b0;
    check("bp_next_accept", {31'd0, bus.in_ready}, 32'd0);
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 20) begin
        tick();
        n++;
      end
      check("bp_next_latency", n, 32'd4);
    end
    check("bp_next_data", {16'd0, bus.out_data}, 32'hAAAA);
    check("bp_next_parity", {20'd0, bus.out_parity}, 32'hB6D);
    tick();
    ws_exp = ws_exp + 16'd1;
    check("bp_next_words", {16'd0, words_sent}, {16'd0, ws_exp});

    // reset in the middle of ENCODE
    bus.in_data  = 16'h1234;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_words", {16'd0, words_sent}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.out_valid) seen++;
      end
      check("midrst_no_stale", seen, 32'd0);
    end

    // wrap of words_sent: preload counter at 0xFFFF while idle
    @(negedge clk);
    force dut.words_sent_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.words_sent_q;
    run_word(16'h0001, 16'h5555, 12'h007);
    tick();
    check("wrap_words", {16'd0, words_sent}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
